axi_write_arbiter: RTL and testbench



---
 rtl/axi_write_arbiter_pkg.sv | 39 +++
 rtl/axi_write_arbiter_if.sv | 36 +++
 rtl/axi_write_arbiter_addr_decoder.sv | 40 ++++
 rtl/axi_write_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and constants for the AXI write arbiter and its address
// decoder: FSM state encoding, slave indices, address-region map, BRESP code.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_arb_state_e;

  localparam int NUM_MST = 2;
  localparam int NUM_SLV = 6;

  localparam int SLV_ROM  = 0;
  localparam int SLV_IM   = 1;
  localparam int SLV_DM   = 2;
  localparam int SLV_DMA  = 3;
  localparam int SLV_WDT  = 4;
  localparam int SLV_DRAM = 5;

  // Regions are matched on address bits [31:16]
  localparam logic [15:0] ROM_BASE   = 16'h0000;
  localparam logic [15:0] IM_BASE    = 16'h0001;
  localparam logic [15:0] DM_BASE    = 16'h0002;
  localparam logic [15:0] DMA_BASE   = 16'h1002;
  localparam logic [15:0] WDT_BASE   = 16'h1001;
  localparam logic [15:0] DRAM_BASE  = 16'h2000;
  localparam logic [15:0] DRAM_LIMIT = 16'h201F;

  localparam logic [1:0] BRESP_DECERR = 2'b11;

  function automatic logic [NUM_SLV-1:0] slv_onehot(input int idx);
    logic [NUM_SLV-1:0] one_v;
    one_v = {{(NUM_SLV-1){1'b0}}, 1'b1};
    return one_v << idx;
  endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Handshake and select bundle between the write arbiter and its environment.
// master: the side driving requests/fire strobes; slave: the arbiter itself.
interface axi_write_arbiter_if #(
  parameter int ADDR_W = 32
);
  import axi_arb_pkg::*;

  logic [NUM_MST-1:0] awvalid_m;
  logic [ADDR_W-1:0]  awaddr_m1;
  logic [ADDR_W-1:0]  awaddr_m2;
  logic [NUM_MST-1:0] awready_m;
  logic [NUM_SLV-1:0] awvalid_s;
  logic [NUM_SLV-1:0] awready_s;
  logic               w_fire;
  logic               w_last;
  logic               b_fire;
  logic [NUM_MST-1:0] grant;
  logic [NUM_SLV-1:0] slave_sel;
  logic               decerr_wready;
  logic               decerr_bvalid;
  logic               busy;
  logic               timeout_err;

  modport master (
    output awvalid_m, awaddr_m1, awaddr_m2, awready_s, w_fire, w_last, b_fire,
    input  awready_m, awvalid_s, grant, slave_sel, decerr_wready,
           decerr_bvalid, busy, timeout_err
  );

  modport slave (
    input  awvalid_m, awaddr_m1, awaddr_m2, awready_s, w_fire, w_last, b_fire,
    output awready_m, awvalid_s, grant, slave_sel, decerr_wready,
           decerr_bvalid, busy, timeout_err
  );

endinterface

// File: rtl/axi_write_arbiter_addr_decoder.sv
// Combinational address decoder: upper 16 address bits -> one-hot slave
// select, or decerr when no region matches. Shared with the read arbiter.
module axi_addr_decoder
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               decerr,
  output logic [NUM_SLV-1:0] slave_sel
);

  logic [15:0] region_s;
  logic        unused_lo_s;

  assign region_s    = addr[ADDR_W-1 -: 16];
  assign unused_lo_s = ^addr[ADDR_W-17:0];

  // Map the region field onto a slave, anything unmapped is a decode error
  always_comb begin
    slave_sel = '0;
    decerr    = 1'b0;
    if (region_s == ROM_BASE) begin
      slave_sel = slv_onehot(SLV_ROM);
    end else if (region_s == IM_BASE) begin
      slave_sel = slv_onehot(SLV_IM);
    end else if (region_s == DM_BASE) begin
      slave_sel = slv_onehot(SLV_DM);
    end else if (region_s == DMA_BASE) begin
      slave_sel = slv_onehot(SLV_DMA);
    end else if (region_s == WDT_BASE) begin
      slave_sel = slv_onehot(SLV_WDT);
    end else if ((region_s >= DRAM_BASE) && (region_s <= DRAM_LIMIT)) begin
      slave_sel = slv_onehot(SLV_DRAM);
    end else begin
      decerr = 1'b1;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// AXI write-path arbiter: round-robin between M1 (CPU) and M2 (DMA), decodes
// the target slave and holds the pairing from AW through B. Unmapped writes
// are absorbed internally with DECERR.
// Optional watchdog: define AXI_WR_ARB_TIMEOUT_EN to abort stuck transactions.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  axi_write_arbiter_if.slave bus
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT - 1);

  wr_arb_state_e      state_r;
  logic [NUM_MST-1:0] grant_r;
  logic [NUM_SLV-1:0] sel_r;
  logic               decerr_r;
  logic               rr_ptr_r;     // 0: M1 wins a tie, 1: M2 wins a tie
  logic               wready_r;
  logic               bvalid_r;
  logic               busy_r;
  logic               tmo_err_r;

  logic               pick_m2_s;
  logic [ADDR_W-1:0]  req_addr_s;
  logic               dec_err_s;
  logic [NUM_SLV-1:0] dec_sel_s;
  logic [NUM_MST-1:0] awready_m_s;
  logic [NUM_SLV-1:0] awvalid_s_s;
  logic               aw_fire_s;
  logic               tmo_hit_s;

  // Choose the requester that would win arbitration this cycle
  always_comb begin
    pick_m2_s  = 1'b0;
    req_addr_s = bus.awaddr_m1;
    if (bus.awvalid_m == 2'b10) begin
      pick_m2_s = 1'b1;
    end else if (bus.awvalid_m == 2'b11) begin
      pick_m2_s = rr_ptr_r;
    end else begin
      pick_m2_s = 1'b0;
    end
    if (pick_m2_s) begin
      req_addr_s = bus.awaddr_m2;
    end else begin
      req_addr_s = bus.awaddr_m1;
    end
  end

  axi_addr_decoder #(
    .ADDR_W   (ADDR_W)
  ) u_dec (
    .addr     (req_addr_s),
    .decerr   (dec_err_s),
    .slave_sel(dec_sel_s)
  );

  // Route the AW handshake between the granted master and selected slave
  always_comb begin
    awvalid_s_s = '0;
    awready_m_s = '0;
    if (state_r == ST_ADDR) begin
      if (decerr_r) begin
        awready_m_s = grant_r;
      end else begin
        awvalid_s_s = sel_r & {NUM_SLV{|(bus.awvalid_m & grant_r)}};
        awready_m_s = grant_r & {NUM_MST{|(bus.awready_s & sel_r)}};
      end
    end else begin
      awvalid_s_s = '0;
      awready_m_s = '0;
    end
  end

  assign aw_fire_s = |(awvalid_s_s & bus.awready_s);

`ifdef AXI_WR_ARB_TIMEOUT_EN
  logic [15:0]   tmo_cnt_r;
  wr_arb_state_e last_state_r;
  logic [15:0]   tmo_cur_s;

  // A state change restarts the count; this is the cycle index in the state
  assign tmo_cur_s = (state_r != last_state_r) ? 16'd0 : tmo_cnt_r;
  assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cur_s == TMO_LIM);

  // Watchdog counter: cycles spent in the current non-idle state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r    <= 16'd0;
      last_state_r <= ST_IDLE;
    end else begin
      last_state_r <= state_r;
      if (state_r == ST_IDLE) begin
        tmo_cnt_r <= 16'd0;
      end else begin
        tmo_cnt_r <= tmo_cur_s + 16'd1;
      end
    end
  end
`else
  logic unused_tmo_s;

  assign unused_tmo_s = ^TMO_LIM;
  assign tmo_hit_s    = 1'b0;
`endif

  // Transaction FSM with registered grant/select and sink outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= '0;
      sel_r     <= '0;
      decerr_r  <= 1'b0;
      rr_ptr_r  <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      busy_r    <= 1'b0;
      tmo_err_r <= 1'b0;
    end else begin
      tmo_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|bus.awvalid_m) begin
            state_r  <= ST_ADDR;
            grant_r  <= pick_m2_s ? 2'b10 : 2'b01;
            sel_r    <= dec_sel_s;
            decerr_r <= dec_err_s;
            busy_r   <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (decerr_r || aw_fire_s) begin
            state_r  <= ST_DATA;
            wready_r <= decerr_r;
          end
        end
        ST_DATA: begin
          if (bus.w_fire && bus.w_last) begin
            state_r  <= ST_RESP;
            wready_r <= 1'b0;
            bvalid_r <= decerr_r;
          end
        end
        ST_RESP: begin
          if (bus.b_fire) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            sel_r    <= '0;
            decerr_r <= 1'b0;
            bvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            rr_ptr_r <= grant_r[0];
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          grant_r  <= '0;
          sel_r    <= '0;
          decerr_r <= 1'b0;
          wready_r <= 1'b0;
          bvalid_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
      if (tmo_hit_s) begin
        state_r   <= ST_IDLE;
        grant_r   <= '0;
        sel_r     <= '0;
        decerr_r  <= 1'b0;
        wready_r  <= 1'b0;
        bvalid_r  <= 1'b0;
        busy_r    <= 1'b0;
        tmo_err_r <= 1'b1;
        rr_ptr_r  <= ~rr_ptr_r;
      end
    end
  end

  assign bus.awready_m     = awready_m_s;
  assign bus.awvalid_s     = awvalid_s_s;
  assign bus.grant         = grant_r;
  assign bus.slave_sel     = sel_r;
  assign bus.decerr_wready = wready_r;
  assign bus.decerr_bvalid = bvalid_r;
  assign bus.busy          = busy_r;
  assign bus.timeout_err   = tmo_err_r;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed self-checking bench for axi_write_arbiter.
module tb_axi_write_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  axi_write_arbiter_if #(.ADDR_W(32)) bus ();

  axi_write_arbiter #(
    .ADDR_W (32),
    .TIMEOUT(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One complete write; called from a negedge in IDLE
  task automatic serve(input logic [1:0] req, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [1:0] eg, input logic [5:0] es, input int beats,
                       input int stall, input logic dec);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.awvalid_m = req;
    bus.awaddr_m1 = a1;
    bus.awaddr_m2 = a2;
    bus.awready_s = (stall > 0) ? 6'b000000 : 6'b111111;
    #1;
    chk("idle_awready_m", 32'(bus.awready_m), 32'd0);
    chk("idle_awvalid_s", 32'(bus.awvalid_s), 32'd0);
    step();
    chk("addr_grant", 32'(bus.grant), 32'(eg));
    chk("addr_slave_sel", 32'(bus.slave_sel), 32'(es));
    chk("addr_busy", 32'(bus.busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_awvalid_s", 32'(bus.awvalid_s), 32'(es));
      chk("stall_awready_m", 32'(bus.awready_m), 32'd0);
      chk("stall_grant", 32'(bus.grant), 32'(eg));
      step();
    end
    bus.awready_s = 6'b111111;
    #1;
    chk("addr_awvalid_s", 32'(bus.awvalid_s), 32'(es));
    chk("addr_awready_m", 32'(bus.awready_m), 32'(eg));
    chk("addr_wready", 32'(bus.decerr_wready), 32'd0);
    step();
    bus.awvalid_m = req & ~eg;
    #1;
    chk("data_awready_m", 32'(bus.awready_m), 32'd0);
    chk("data_awvalid_s", 32'(bus.awvalid_s), 32'd0);
    chk("data_wready", 32'(bus.decerr_wready), 32'(dec));
    for (int b = 0; b < beats; b++) begin
      bus.w_fire = 1'b1;
      bus.w_last = (b == beats - 1);
      step();
      bus.w_fire = 1'b0;
      bus.w_last = 1'b0;
      if (b < beats - 1) begin
        bus.b_fire = 1'b1;
        step();
        bus.b_fire = 1'b0;
        chk("data_hold_busy", 32'(bus.busy), 32'd1);
        chk("data_hold_grant", 32'(bus.grant), 32'(eg));
        chk("data_hold_wready", 32'(bus.decerr_wready), 32'(dec));
      end
    end
    chk("resp_bvalid", 32'(bus.decerr_bvalid), 32'(dec));
    chk("resp_wready", 32'(bus.decerr_wready), 32'd0);
    chk("resp_grant", 32'(bus.grant), 32'(eg));
    chk("resp_slave_sel", 32'(bus.slave_sel), 32'(es));
    bus.b_fire = 1'b1;
    step();
    bus.b_fire = 1'b0;
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_grant", 32'(bus.grant), 32'd0);
    chk("end_slave_sel", 32'(bus.slave_sel), 32'd0);
    chk("end_bvalid", 32'(bus.decerr_bvalid), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    bus.awvalid_m = 2'b00;
    bus.awaddr_m1 = 32'h0000_0000;
    bus.awaddr_m2 = 32'h0000_0000;
    bus.awready_s = 6'b000000;
    bus.w_fire    = 1'b0;
    bus.w_last    = 1'b0;
    bus.b_fire    = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_slave_sel", 32'(bus.slave_sel), 32'd0);
    chk("rst_awready_m", 32'(bus.awready_m), 32'd0);
    chk("rst_awvalid_s", 32'(bus.awvalid_s), 32'd0);
    chk("rst_wready", 32'(bus.decerr_wready), 32'd0);
    chk("rst_bvalid", 32'(bus.decerr_bvalid), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    rst = 1'b1;
    step();

    // Both masters keep requesting: M1 (pointer at reset), then M2, then M1
    serve(2'b11, 32'h0001_0000, 32'h2000_0000, 2'b01, 6'b000010, 1, 0, 1'b0);
    serve(2'b11, 32'h0001_0000, 32'h2000_0000, 2'b10, 6'b100000, 1, 0, 1'b0);
    serve(2'b11, 32'h0001_0000, 32'h2000_0000, 2'b01, 6'b000010, 1, 0, 1'b0);
    // Lone M1 wins even though the pointer favours M2
    serve(2'b01, 32'h0002_0010, 32'h0000_0000, 2'b01, 6'b000100, 1, 0, 1'b0);
    // M2 4-beat burst to the top of DRAM with a 3-cycle AW stall
    serve(2'b10, 32'h0000_0000, 32'h201F_0000, 2'b10, 6'b100000, 4, 3, 1'b0);
    // Unmapped M1 write completes with DECERR
    serve(2'b01, 32'h3000_0000, 32'h0000_0000, 2'b01, 6'b000000, 1, 0, 1'b1);
    serve(2'b10, 32'h0000_0000, 32'h1002_0000, 2'b10, 6'b001000, 1, 0, 1'b0);
    serve(2'b01, 32'h1001_0004, 32'h0000_0000, 2'b01, 6'b010000, 1, 0, 1'b0);
    serve(2'b10, 32'h0000_0000, 32'h0000_0100, 2'b10, 6'b000001, 1, 0, 1'b0);
    // Just past the DRAM limit is unmapped; two beats into the sink
    serve(2'b01, 32'h2020_0000, 32'h0000_0000, 2'b01, 6'b000000, 2, 0, 1'b1);

    // Reset during DATA (pointer now favours M2)
    bus.awvalid_m = 2'b01;
    bus.awaddr_m1 = 32'h0002_0000;
    bus.awready_s = 6'b111111;
    step();
    step();
    bus.awvalid_m = 2'b00;
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    bus.w_fire = 1'b1;
    step();
    bus.w_fire = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_grant", 32'(bus.grant), 32'd0);
    chk("abort_slave_sel", 32'(bus.slave_sel), 32'd0);
    chk("abort_wready", 32'(bus.decerr_wready), 32'd0);
    step();
    rst = 1'b1;
    step();
    serve(2'b11, 32'h0001_0000, 32'h2000_0000, 2'b01, 6'b000010, 1, 0, 1'b0);

    // No watchdog in this build: stays in DATA while w_fire is held low
    bus.awvalid_m = 2'b10;
    bus.awaddr_m2 = 32'h0002_0000;
    step();
    step();
    bus.awvalid_m = 2'b00;
    for (int i = 0; i < 20; i++) begin
      chk("wait_timeout", 32'(bus.timeout_err), 32'd0);
      chk("wait_busy", 32'(bus.busy), 32'd1);
      step();
    end
    chk("wait_grant", 32'(bus.grant), 32'(2'b10));
    bus.w_fire = 1'b1;
    bus.w_last = 1'b1;
    step();
    bus.w_fire = 1'b0;
    bus.w_last = 1'b0;
    bus.b_fire = 1'b1;
    step();
    bus.b_fire = 1'b0;
    chk("wait_end_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
